demux_1to4_buf: RTL and testbench



---
 rtl/mux_pkg.sv | 27 ++
 rtl/demux_chan_fifo.sv | 68 ++++++
 rtl/demux_1to4_buf.sv | 75 +++++++
 tb/tb_demux_1to4_buf.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared select encoding for the 4-to-1 selector and the 1-to-4 demux.
// Latency: none (types, constants and a pure decode function only).
// Backpressure: not applicable.
// Contents: sel_t, SEL_CH1..SEL_CH4, NUM_CH, sel_to_idx().
package mux_pkg;

  typedef logic [1:0] sel_t;

  // {I1,I0} encodings; kept identical to the selector so demux->mux round-trips.
  localparam sel_t SEL_CH1 = 2'b01;
  localparam sel_t SEL_CH2 = 2'b00;
  localparam sel_t SEL_CH3 = 2'b11;
  localparam sel_t SEL_CH4 = 2'b10;

  localparam int NUM_CH = 4;

  // Maps a select code to a zero-based channel index (ch1 -> 0 ... ch4 -> 3).
  function automatic logic [1:0] sel_to_idx(input sel_t sel);
    case (sel)
      SEL_CH1: return 2'd0;
      SEL_CH2: return 2'd1;
      SEL_CH3: return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/demux_chan_fifo.sv
// Per-channel FIFO for the buffered demux: registered storage, no write-through.
// Latency: a word pushed at edge k is on dout/valid after edge k.
// Backpressure: full is raised at DEPTH entries; pushes while full and pops while empty are ignored.
// Ports: clk, rst (sync, active-high), push/din (write), pop (remove head),
//        dout (head word, 0 until first write), valid (non-empty), full.
module demux_chan_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == CW'(DEPTH));
  assign valid = (count != '0);
  assign dout  = mem[rd_ptr];

  // A pop on an empty FIFO is dropped, so a same-cycle push+pop on empty
  // leaves exactly the new word behind.
  assign do_push = push && !full;
  assign do_pop  = pop && valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      // Storage is cleared so dout reads 0 rather than X until the first write.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  a_count_bound: assert property (@(posedge clk) disable iff (rst) count <= CW'(DEPTH));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) do_pop |-> count != '0);
  a_no_push_full: assert property (@(posedge clk) disable iff (rst) push |-> !full);

endmodule

// File: rtl/demux_1to4_buf.sv
// Buffered 1-to-4 demux: steers each accepted word to one of four channel FIFOs by {I1,I0}.
// Latency: one cycle from accept edge to qn/qn_valid (no bypass).
// Backpressure: d_ready = !full[target]; a stalled channel only blocks traffic aimed at it.
// Ports: clk, rst (sync, active-high); d/d_valid/d_ready with select I0/I1;
//        q1..q4 + qn_valid/qn_ready per channel; full[3:0] (bit n-1 = channel n).
module demux_1to4_buf
  import mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic             d_ready,
  input  logic             I0,
  input  logic             I1,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2,
  output logic [WIDTH-1:0] q3,
  output logic [WIDTH-1:0] q4,
  output logic             q1_valid,
  output logic             q2_valid,
  output logic             q3_valid,
  output logic             q4_valid,
  input  logic             q1_ready,
  input  logic             q2_ready,
  input  logic             q3_ready,
  input  logic             q4_ready,
  output logic [3:0]       full
);

  logic [1:0]       tgt;
  logic [3:0]       push_en;
  logic [3:0]       pop_en;
  logic [3:0]       ch_vld;
  logic [WIDTH-1:0] ch_dat [NUM_CH];

  assign tgt = sel_to_idx({I1, I0});

  // Ready looks only at the addressed channel's current full flag; a pop on
  // that channel in the same cycle does not open the slot until next cycle.
  assign d_ready = !full[tgt];

  assign push_en = (d_valid && d_ready) ? (4'b0001 << tgt) : 4'b0000;
  assign pop_en  = {q4_ready, q3_ready, q2_ready, q1_ready};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    demux_chan_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_en[g]),
      .din   (d),
      .pop   (pop_en[g]),
      .dout  (ch_dat[g]),
      .valid (ch_vld[g]),
      .full  (full[g])
    );
  end

  assign q1 = ch_dat[0];
  assign q2 = ch_dat[1];
  assign q3 = ch_dat[2];
  assign q4 = ch_dat[3];

  assign q1_valid = ch_vld[0];
  assign q2_valid = ch_vld[1];
  assign q3_valid = ch_vld[2];
  assign q4_valid = ch_vld[3];

endmodule

// File: tb/tb_demux_1to4_buf.sv
// Self-checking bench for demux_1to4_buf with a queue-based reference model.
// Latency: model updates at each rising edge using pre-edge inputs.
// Backpressure: consumer readies are driven directed or randomly per test.
module tb_demux_1to4_buf;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] d;
  logic         d_valid;
  logic         d_ready;
  logic         I0, I1;
  logic [W-1:0] q1, q2, q3, q4;
  logic         q1_valid, q2_valid, q3_valid, q4_valid;
  logic         q1_ready, q2_ready, q3_ready, q4_ready;
  logic [3:0]   full;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one queue per channel, head at index 0.
  logic [W-1:0] mq [4][$];

  logic [3:0]   qv;
  logic [W-1:0] qd [4];
  assign qv    = {q4_valid, q3_valid, q2_valid, q1_valid};
  assign qd[0] = q1;
  assign qd[1] = q2;
  assign qd[2] = q3;
  assign qd[3] = q4;

  demux_1to4_buf #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .d(d), .d_valid(d_valid), .d_ready(d_ready),
    .I0(I0), .I1(I1),
    .q1(q1), .q2(q2), .q3(q3), .q4(q4),
    .q1_valid(q1_valid), .q2_valid(q2_valid), .q3_valid(q3_valid), .q4_valid(q4_valid),
    .q1_ready(q1_ready), .q2_ready(q2_ready), .q3_ready(q3_ready), .q4_ready(q4_ready),
    .full(full)
  );

  always #5 clk = ~clk;

  // Channel table: {I1,I0} 01->ch1, 00->ch2, 11->ch3, 10->ch4 (zero-based index).
  function automatic int chan_of(input logic i1, input logic i0);
    case ({i1, i0})
      2'b01:   return 0;
      2'b00:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic drive(input logic [W-1:0] dv, input logic vld, input logic [1:0] sel,
                       input logic [3:0] rdy);
    d       = dv;
    d_valid = vld;
    I1      = sel[1];
    I0      = sel[0];
    {q4_ready, q3_ready, q2_ready, q1_ready} = rdy;
  endtask

  // Advance one clock, applying the same edge to the model.
  task automatic tick();
    int         t;
    bit         acc;
    logic [3:0] r;
    t   = chan_of(I1, I0);
    r   = {q4_ready, q3_ready, q2_ready, q1_ready};
    acc = d_valid && (mq[t].size() < D);
    if (rst) begin
      for (int c = 0; c < 4; c++) mq[c].delete();
    end else begin
      for (int c = 0; c < 4; c++)
        if (r[c] && mq[c].size() != 0) void'(mq[c].pop_front());
      if (acc) mq[t].push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    drive('0, 1'b0, 2'b00, 4'b0000);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    #1;
    n_checks++;
    if (qv !== 4'b0000) begin n_fail++; $display("FAIL reset_valid: got %b expected 0000", qv); end
    n_checks++;
    if (full !== 4'b0000) begin n_fail++; $display("FAIL reset_full: got %b expected 0000", full); end
    n_checks++;
    if (d_ready !== 1'b1) begin n_fail++; $display("FAIL reset_d_ready: got %b expected 1", d_ready); end
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (qd[c] !== 8'h00) begin n_fail++; $display("FAIL reset_q%0d: got %h expected 00", c + 1, qd[c]); end
    end
  endtask

  task automatic test_routing();
    logic [W-1:0] vals [4];
    logic [1:0]   sels [4];
    vals = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    sels = '{2'b01, 2'b00, 2'b11, 2'b10};
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      drive(vals[i], 1'b1, sels[i], 4'b0000);
      #1;
      n_checks++;
      if (d_ready !== 1'b1) begin n_fail++; $display("FAIL route_ready%0d: got %b expected 1", i, d_ready); end
      n_checks++;
      if (qv[i] !== 1'b0) begin n_fail++; $display("FAIL route_no_bypass%0d: got %b expected 0", i, qv[i]); end
      tick();
      drive('0, 1'b0, sels[i], 4'b0000);
      #1;
      n_checks++;
      if (qv[i] !== 1'b1 || qd[i] !== vals[i]) begin
        n_fail++; $display("FAIL route_q%0d: got v=%b %h expected v=1 %h", i + 1, qv[i], qd[i], vals[i]);
      end
    end
    n_checks++;
    if (qv !== 4'b1111 || q1 !== 8'hA1 || q2 !== 8'hB2 || q3 !== 8'hC3 || q4 !== 8'hD4) begin
      n_fail++; $display("FAIL route_all: got v=%b %h %h %h %h expected 1111 a1 b2 c3 d4", qv, q1, q2, q3, q4);
    end
  endtask

  task automatic test_fill_backpressure();
    reset_dut();
    for (int v = 1; v <= 4; v++) begin
      drive(W'(v), 1'b1, 2'b11, 4'b0000);
      #1;
      n_checks++;
      if (d_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready%0d: got %b expected 1", v, d_ready); end
      tick();
    end
    drive(8'd5, 1'b1, 2'b11, 4'b0000);
    #1;
    n_checks++;
    if (full !== 4'b0100) begin n_fail++; $display("FAIL fill_full: got %b expected 0100", full); end
    n_checks++;
    if (d_ready !== 1'b0) begin n_fail++; $display("FAIL fill_stall: got %b expected 0", d_ready); end
    drive(8'd5, 1'b1, 2'b01, 4'b0000);
    #1;
    n_checks++;
    if (d_ready !== 1'b1) begin n_fail++; $display("FAIL fill_redirect: got %b expected 1", d_ready); end
    tick();
    drive('0, 1'b0, 2'b01, 4'b0000);
    #1;
    n_checks++;
    if (qv !== 4'b0101 || q1 !== 8'd5 || q3 !== 8'd1) begin
      n_fail++; $display("FAIL fill_after: got v=%b q1=%h q3=%h expected 0101 05 01", qv, q1, q3);
    end
  endtask

  task automatic test_full_pop_wrap();
    logic [W-1:0] obs [$];
    int           nxt;
    bool_loop: begin end
    reset_dut();
    for (int v = 1; v <= 4; v++) begin
      drive(W'(v), 1'b1, 2'b11, 4'b0000);
      tick();
    end
    drive(8'd5, 1'b1, 2'b11, 4'b0100);
    #1;
    n_checks++;
    if (d_ready !== 1'b0) begin n_fail++; $display("FAIL fullpop_refuse: got %b expected 0", d_ready); end
    if (q3_valid) obs.push_back(q3);
    tick();
    drive(8'd5, 1'b1, 2'b11, 4'b0100);
    #1;
    n_checks++;
    if (d_ready !== 1'b1) begin n_fail++; $display("FAIL fullpop_next: got %b expected 1", d_ready); end
    nxt = 5;
    for (int n = 0; n < 20 && obs.size() < 6; n++) begin
      drive((nxt <= 6) ? W'(nxt) : '0, nxt <= 6, 2'b11, 4'b0100);
      #1;
      if (q3_valid) obs.push_back(q3);
      if (d_valid && d_ready) nxt++;
      tick();
    end
    n_checks++;
    if (obs.size() != 6) begin n_fail++; $display("FAIL wrap_count: got %0d expected 6", obs.size()); end
    for (int i = 0; i < obs.size(); i++) begin
      n_checks++;
      if (obs[i] !== W'(i + 1)) begin n_fail++; $display("FAIL wrap_order%0d: got %h expected %h", i, obs[i], W'(i + 1)); end
    end
  endtask

  task automatic test_empty_push_pop();
    reset_dut();
    drive(8'h5A, 1'b1, 2'b00, 4'b0010);
    #1;
    n_checks++;
    if (q2_valid !== 1'b0 || d_ready !== 1'b1) begin
      n_fail++; $display("FAIL epp_before: got v=%b rdy=%b expected v=0 rdy=1", q2_valid, d_ready);
    end
    tick();
    drive('0, 1'b0, 2'b00, 4'b0000);
    #1;
    n_checks++;
    if (q2_valid !== 1'b1 || q2 !== 8'h5A) begin
      n_fail++; $display("FAIL epp_after: got v=%b %h expected v=1 5a", q2_valid, q2);
    end
  endtask

  task automatic test_mid_reset();
    reset_dut();
    for (int v = 0; v < 3; v++) begin
      drive(W'(8'h31 + v), 1'b1, 2'b10, 4'b0000);
      tick();
    end
    drive('0, 1'b0, 2'b10, 4'b0000);
    #1;
    n_checks++;
    if (q4_valid !== 1'b1 || q4 !== 8'h31) begin n_fail++; $display("FAIL mrst_pre: got v=%b %h expected v=1 31", q4_valid, q4); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (q4_valid !== 1'b0 || full !== 4'b0000 || q4 !== 8'h00 || d_ready !== 1'b1) begin
      n_fail++; $display("FAIL mrst_post: got v=%b full=%b q4=%h rdy=%b expected 0 0000 00 1", q4_valid, full, q4, d_ready);
    end
    drive('0, 1'b0, 2'b10, 4'b1111);
    repeat (3) tick();
    n_checks++;
    if (qv !== 4'b0000) begin n_fail++; $display("FAIL mrst_idle: got %b expected 0000", qv); end
    drive(8'h77, 1'b1, 2'b10, 4'b0000);
    tick();
    drive('0, 1'b0, 2'b10, 4'b0000);
    #1;
    n_checks++;
    if (q4_valid !== 1'b1 || q4 !== 8'h77) begin n_fail++; $display("FAIL mrst_new: got v=%b %h expected v=1 77", q4_valid, q4); end
  endtask

  task automatic test_random();
    int t;
    reset_dut();
    for (int n = 0; n < 400; n++) begin
      rst = (n == 200);
      drive(W'($urandom), $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
            4'($urandom_range(0, 15) & $urandom_range(0, 15)));
      #1;
      if (!rst) begin
        t = chan_of(I1, I0);
        n_checks++;
        if (d_ready !== (mq[t].size() < D)) begin
          n_fail++; $display("FAIL rnd_ready@%0d: got %b expected %b", n, d_ready, mq[t].size() < D);
        end
        for (int c = 0; c < 4; c++) begin
          n_checks++;
          if (full[c] !== (mq[c].size() == D) || qv[c] !== (mq[c].size() != 0)) begin
            n_fail++; $display("FAIL rnd_flags@%0d ch%0d: got full=%b v=%b expected size %0d", n, c + 1, full[c], qv[c], mq[c].size());
          end
          if (mq[c].size() != 0) begin
            n_checks++;
            if (qd[c] !== mq[c][0]) begin
              n_fail++; $display("FAIL rnd_data@%0d ch%0d: got %h expected %h", n, c + 1, qd[c], mq[c][0]);
            end
          end
        end
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive('0, 1'b0, 2'b00, 4'b0000);
    test_reset();
    test_routing();
    test_fill_backpressure();
    test_full_pop_wrap();
    test_empty_push_pop();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
